// File: rtl/dmem_pkg.sv
// Shared types, default sizing and the byte-lane merge helper for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_DEPTH_DEF   = 64;
  localparam int DMEM_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Lanes with be=1 take the new byte, the rest keep the old one.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: byte-enabled synchronous write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= be_merge(mem_q[idx_i], wdata_i, be_i);
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accept one request, wait LATENCY cycles,
// access the array on the edge entering RESP, then hold the response until it is taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEF,
  parameter int LATENCY = DMEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wr_strobe,
  output logic [31:0] last_wr_addr,
  output logic [31:0] last_wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 2;

  dmem_state_e   state_q, state_d;
  logic          ready_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          cap_we_q;
  logic [31:0]   cap_addr_q;
  logic [31:0]   cap_wdata_q;
  logic [3:0]    cap_be_q;

  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [31:0]   last_wr_addr_q, last_wr_addr_d;
  logic [31:0]   last_wr_data_q, last_wr_data_d;

  logic          accept;
  logic          enter_resp;
  logic          use_live;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] mem_idx;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic [31:0]   merged_word;

  // ready_q keeps req_ready low until the first edge after reset release.
  assign req_ready = ready_q & (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs are used.
  assign use_live  = (state_q == ST_IDLE);
  assign acc_we    = use_live ? req_we    : cap_we_q;
  assign acc_addr  = use_live ? req_addr  : cap_addr_q;
  assign acc_wdata = use_live ? req_wdata : cap_wdata_q;
  assign acc_be    = use_live ? req_be    : cap_be_q;

  assign acc_err     = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
  assign mem_idx     = acc_addr[AW+1:2];
  assign merged_word = be_merge(mem_rdata, acc_wdata, acc_be);
  assign mem_we      = enter_resp & acc_we & ~acc_err & (|acc_be);

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .idx_i   (mem_idx),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    enter_resp     = 1'b0;
    rdata_d        = rdata_q;
    err_d          = err_q;
    wr_strobe_d    = 1'b0;
    last_wr_addr_d = last_wr_addr_q;
    last_wr_data_d = last_wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'h0 : mem_rdata;
      if (mem_we) begin
        wr_strobe_d    = 1'b1;
        last_wr_addr_d = acc_addr;
        last_wr_data_d = merged_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ready_q        <= 1'b0;
      cnt_q          <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      wr_strobe_q    <= 1'b0;
      last_wr_addr_q <= '0;
      last_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      ready_q        <= 1'b1;
      cnt_q          <= cnt_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
      wr_strobe_q    <= wr_strobe_d;
      last_wr_addr_q <= last_wr_addr_d;
      last_wr_data_q <= last_wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_be_q    <= '0;
    end else if (accept) begin
      cap_we_q    <= req_we;
      cap_addr_q  <= req_addr;
      cap_wdata_q <= req_wdata;
      cap_be_q    <= req_be;
    end
  end

  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign wr_strobe    = wr_strobe_q;
  assign last_wr_addr = last_wr_addr_q;
  assign last_wr_data = last_wr_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hold/reset sequences,
// then randomized traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wr_strobe;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .wr_strobe    (wr_strobe),
    .last_wr_addr (last_wr_addr),
    .last_wr_data (last_wr_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain word array plus the last committed write.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_laddr = '0;
  logic [31:0] m_ldata = '0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] e_rdata;
    bit          e_err;
    bit          e_strobe;
    logic [31:0] e_laddr;
    logic [31:0] e_ldata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] e_rdata, output bit e_err,
                            output bit e_strobe);
    int unsigned word;
    word     = addr / 4;
    e_err    = (addr % 4 != 0) || (word >= DEPTH);
    e_rdata  = (!e_err && !we) ? m_mem[word] : 32'h0;
    e_strobe = we && !e_err && (be != 4'b0000);
    if (e_strobe) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m_mem[word][8*b +: 8] = wdata[8*b +: 8];
      end
      m_laddr = addr;
      m_ldata = m_mem[word];
    end
  endtask

  task automatic drive_garbage();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
  endtask

  // Entered and left at #1 after a rising edge with the responder idle.
  task automatic run_txn(input string tag, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold,
                         input logic [31:0] e_rdata, input bit e_err, input bit e_strobe,
                         input logic [31:0] e_laddr, input logic [31:0] e_ldata);
    int n, lat, strobes;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "/accept_in_time"}, 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    drive_garbage();
    lat = 1;
    strobes = int'(wr_strobe);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      strobes += int'(wr_strobe);
    end
    chk({tag, "/latency"}, 32'(lat), 32'(LAT));
    chk({tag, "/rdata"}, rsp_rdata, e_rdata);
    chk({tag, "/err"}, 32'(rsp_err), 32'(e_err));
    chk({tag, "/last_wr_addr"}, last_wr_addr, e_laddr);
    chk({tag, "/last_wr_data"}, last_wr_data, e_ldata);
    for (int h = 0; h < hold; h++) begin
      drive_garbage();
      @(posedge clk); #1;
      strobes += int'(wr_strobe);
      chk({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "/hold_rdata"}, rsp_rdata, e_rdata);
      chk({tag, "/hold_err"}, 32'(rsp_err), 32'(e_err));
      chk({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "/done_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/done_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "/strobe_count"}, 32'(strobes), 32'(e_strobe));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "/rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "/wr_strobe"}, 32'(wr_strobe), 32'd0);
    chk({tag, "/last_wr_addr"}, last_wr_addr, 32'd0);
    chk({tag, "/last_wr_data"}, last_wr_data, 32'd0);
  endtask

  vec_t        vecs [16];
  logic [31:0] e_rd;
  bit          e_er, e_st;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    vecs[0]  = '{1'b1, 32'h64, 32'd25,        4'hF, 0, 32'h0,        1'b0, 1'b1, 32'h64, 32'h19};
    vecs[1]  = '{1'b0, 32'h64, 32'h0,         4'hF, 1, 32'h19,       1'b0, 1'b0, 32'h64, 32'h19};
    vecs[2]  = '{1'b1, 32'h60, 32'h11223344,  4'hF, 0, 32'h0,        1'b0, 1'b1, 32'h60, 32'h11223344};
    vecs[3]  = '{1'b1, 32'h60, 32'h000000AB,  4'h1, 0, 32'h0,        1'b0, 1'b1, 32'h60, 32'h112233AB};
    vecs[4]  = '{1'b0, 32'h60, 32'h0,         4'h3, 0, 32'h112233AB, 1'b0, 1'b0, 32'h60, 32'h112233AB};
    vecs[5]  = '{1'b1, 32'h62, 32'hDEADBEEF,  4'hF, 0, 32'h0,        1'b1, 1'b0, 32'h60, 32'h112233AB};
    vecs[6]  = '{1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 1, 32'h0,        1'b1, 1'b0, 32'h60, 32'h112233AB};
    vecs[7]  = '{1'b0, 32'h60, 32'h0,         4'hF, 0, 32'h112233AB, 1'b0, 1'b0, 32'h60, 32'h112233AB};
    vecs[8]  = '{1'b1, 32'h60, 32'hFFFFFFFF,  4'h0, 0, 32'h0,        1'b0, 1'b0, 32'h60, 32'h112233AB};
    vecs[9]  = '{1'b0, 32'h60, 32'h0,         4'hF, 0, 32'h112233AB, 1'b0, 1'b0, 32'h60, 32'h112233AB};
    vecs[10] = '{1'b1, 32'hFC, 32'hA5A5A5A5,  4'hF, 0, 32'h0,        1'b0, 1'b1, 32'hFC, 32'hA5A5A5A5};
    vecs[11] = '{1'b0, 32'hFC, 32'h0,         4'hF, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hFC, 32'hA5A5A5A5};
    vecs[12] = '{1'b0, 32'h102, 32'h0,        4'hF, 0, 32'h0,        1'b1, 1'b0, 32'hFC, 32'hA5A5A5A5};
    vecs[13] = '{1'b1, 32'h0,  32'h01020304,  4'hF, 0, 32'h0,        1'b0, 1'b1, 32'h0,  32'h01020304};
    vecs[14] = '{1'b1, 32'h0,  32'hAABBCCDD,  4'hA, 0, 32'h0,        1'b0, 1'b1, 32'h0,  32'hAA02CC04};
    vecs[15] = '{1'b0, 32'h0,  32'h0,         4'h0, 0, 32'hAA02CC04, 1'b0, 1'b0, 32'h0,  32'hAA02CC04};

    // Power-on reset, then release between edges.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("por_release/req_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("por_release/req_ready_after_edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
              vecs[i].hold, vecs[i].e_rdata, vecs[i].e_err, vecs[i].e_strobe,
              vecs[i].e_laddr, vecs[i].e_ldata);
      model_step(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, e_rd, e_er, e_st);
    end

    // Response held off for five cycles.
    model_step(1'b0, 32'h60, 32'h0, 4'hF, e_rd, e_er, e_st);
    run_txn("hold5", 1'b0, 32'h60, 32'h0, 4'hF, 5, 32'h112233AB, 1'b0, 1'b0, m_laddr, m_ldata);

    // Reset during BUSY of a write: no response, no commit, outputs cleared at once.
    model_step(1'b1, 32'h68, 32'h12345678, 4'hF, e_rd, e_er, e_st);
    run_txn("pre68", 1'b1, 32'h68, 32'h12345678, 4'hF, 0, 32'h0, 1'b0, 1'b1, 32'h68, 32'h12345678);
    req_we = 1'b1; req_addr = 32'h68; req_wdata = 32'h0; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_busy/in_busy_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_busy");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_busy/held_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy/held_wr_strobe", 32'(wr_strobe), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    m_laddr = '0;
    m_ldata = '0;
    @(posedge clk); #1;
    chk("rst_busy/req_ready_after_release", 32'(req_ready), 32'd1);
    model_step(1'b0, 32'h68, 32'h0, 4'hF, e_rd, e_er, e_st);
    run_txn("post68", 1'b0, 32'h68, 32'h0, 4'hF, 0, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fill every word so random reads always hit known data.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] a, d;
      a = 32'(i * 4);
      d = $urandom;
      model_step(1'b1, a, d, 4'hF, e_rd, e_er, e_st);
      run_txn($sformatf("fill%0d", i), 1'b1, a, d, 4'hF, 0, e_rd, e_er, e_st, m_laddr, m_ldata);
    end

    for (int t = 0; t < 200; t++) begin
      bit          we;
      logic [31:0] a, d;
      logic [3:0]  be;
      int          sel;
      we  = 1'($urandom_range(0, 1));
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(DEPTH, 4 * DEPTH) * 4);
      else               a = $urandom;
      model_step(we, a, d, be, e_rd, e_er, e_st);
      run_txn($sformatf("rnd%0d", t), we, a, d, be, $urandom_range(0, 2),
              e_rd, e_er, e_st, m_laddr, m_ldata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
